// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one register-block local bus between REQUESTERS masters.
// Optional downstream timeout: define RGGEN_BUS_ARBITER_TIMEOUT_EN.
module rggen_bus_arbiter #(
    parameter int REQUESTERS     = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQUESTERS-1:0]            i_request,
    input  logic [REQUESTERS-1:0]            i_write,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] i_write_data,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] i_strobe,
    output logic [REQUESTERS-1:0]            o_done,
    output logic [DATA_WIDTH-1:0]            o_read_data,
    output logic [1:0]                       o_status,
    output logic                             o_bus_request,
    output logic                             o_bus_write,
    output logic [ADDRESS_WIDTH-1:0]         o_bus_address,
    output logic [DATA_WIDTH-1:0]            o_bus_write_data,
    output logic [DATA_WIDTH-1:0]            o_bus_strobe,
    input  logic                             i_bus_done,
    input  logic [DATA_WIDTH-1:0]            i_bus_read_data,
    input  logic [1:0]                       i_bus_status
);

    localparam int GW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    // Handshake: a requester holds i_request and its payload until it sees its
    // o_done pulse; downstream, o_bus_request stays high with a stable command
    // until the cycle i_bus_done is sampled high.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [GW-1:0]           r_grant;
    logic [GW-1:0]           r_last;
    logic [GW-1:0]           w_grant;
    logic [GW-1:0]           w_idx;
    logic                    w_found;
    logic                    r_write;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0]   r_write_data;
    logic [DATA_WIDTH-1:0]   r_strobe;
    logic [DATA_WIDTH-1:0]   r_read_data;
    logic [1:0]              r_status;
    logic                    w_timeout;
    logic [REQUESTERS-1:0]   w_done;

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TW-1:0] r_timer;

    // Counts completed BUSY cycles; expiring on the last one bounds BUSY to TIMEOUT_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (r_state != ST_BUSY) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_BUSY) && (r_timer == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Search starts one past the last grant so every requester is reached within REQUESTERS turns.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_last;
        w_idx   = '0;
        for (int ofs = 1; ofs <= REQUESTERS; ofs++) begin
            w_idx = GW'((int'(r_last) + ofs) % REQUESTERS);
            if (!w_found && i_request[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_bus_done || w_timeout) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_last       <= GW'(REQUESTERS - 1);
            r_write      <= 1'b0;
            r_address    <= '0;
            r_write_data <= '0;
            r_strobe     <= '0;
            r_read_data  <= '0;
            r_status     <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_grant;
                        r_last       <= w_grant;
                        r_write      <= i_write[w_grant];
                        r_address    <= i_address[int'(w_grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        r_write_data <= i_write_data[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
                        r_strobe     <= i_strobe[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ST_BUSY: begin
                    // A completion in the same cycle as the timeout is honoured as a normal response.
                    if (i_bus_done) begin
                        r_read_data <= r_write ? '0 : i_bus_read_data;
                        r_status    <= i_bus_status;
                    end else if (w_timeout) begin
                        r_read_data <= '0;
                        r_status    <= 2'b10;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_done = '0;
        if (r_state == ST_DONE) begin
            w_done[r_grant] = 1'b1;
        end
    end

    assign o_done           = w_done;
    assign o_read_data      = (r_state == ST_DONE) ? r_read_data : '0;
    assign o_status         = (r_state == ST_DONE) ? r_status : 2'b00;
    assign o_bus_request    = (r_state == ST_BUSY);
    assign o_bus_write      = r_write;
    assign o_bus_address    = r_address;
    assign o_bus_write_data = r_write_data;
    assign o_bus_strobe     = r_strobe;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench for rggen_bus_arbiter (two requesters, TIMEOUT_CYCLES = 4).
module tb_rggen_bus_arbiter;

    localparam int REQ = 2;
    localparam int AW  = 8;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [REQ-1:0]    i_request;
    logic [REQ-1:0]    i_write;
    logic [REQ*AW-1:0] i_address;
    logic [REQ*DW-1:0] i_write_data;
    logic [REQ*DW-1:0] i_strobe;
    logic [REQ-1:0]    o_done;
    logic [DW-1:0]     o_read_data;
    logic [1:0]        o_status;
    logic              o_bus_request;
    logic              o_bus_write;
    logic [AW-1:0]     o_bus_address;
    logic [DW-1:0]     o_bus_write_data;
    logic [DW-1:0]     o_bus_strobe;
    logic              i_bus_done;
    logic [DW-1:0]     i_bus_read_data;
    logic [1:0]        i_bus_status;

    int n_vec = 0;
    int n_err = 0;

    rggen_bus_arbiter #(
        .REQUESTERS     (REQ),
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_request        (i_request),
        .i_write          (i_write),
        .i_address        (i_address),
        .i_write_data     (i_write_data),
        .i_strobe         (i_strobe),
        .o_done           (o_done),
        .o_read_data      (o_read_data),
        .o_status         (o_status),
        .o_bus_request    (o_bus_request),
        .o_bus_write      (o_bus_write),
        .o_bus_address    (o_bus_address),
        .o_bus_write_data (o_bus_write_data),
        .o_bus_strobe     (o_bus_strobe),
        .i_bus_done       (i_bus_done),
        .i_bus_read_data  (i_bus_read_data),
        .i_bus_status     (i_bus_status)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic k, input logic en, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW-1:0] s);
        i_request[k]          = en;
        i_write[k]            = wr;
        i_address[k*AW +: AW] = a;
        i_write_data[k*DW +: DW] = d;
        i_strobe[k*DW +: DW]  = s;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        i_request       = '0;
        i_write         = '0;
        i_address       = '0;
        i_write_data    = '0;
        i_strobe        = '0;
        i_bus_done      = 1'b0;
        i_bus_read_data = '0;
        i_bus_status    = 2'b00;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({o_done, o_bus_request, o_bus_write, o_status} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 000000", {o_done, o_bus_request, o_bus_write, o_status});
        end
        n_vec++;
        if ({o_read_data, o_bus_address, o_bus_write_data, o_bus_strobe} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h expected 0", {o_read_data, o_bus_address, o_bus_write_data, o_bus_strobe});
        end
    endtask

    task automatic test_single_read();
        drive_req(1'b0, 1'b1, 1'b0, 8'h08, 32'h0, 32'hFFFF_FFFF);
        step();
        n_vec++;
        if ({o_bus_request, o_bus_write, o_bus_address} !== {1'b1, 1'b0, 8'h08}) begin
            n_err++;
            $display("FAIL read_busy: got req/wr/addr %b/%b/%h expected 1/0/08", o_bus_request, o_bus_write, o_bus_address);
        end
        step();
        n_vec++;
        if ({o_bus_request, o_done} !== 3'b100) begin
            n_err++;
            $display("FAIL read_wait1: got req/done %b/%b expected 1/00", o_bus_request, o_done);
        end
        step();
        n_vec++;
        if ({o_bus_request, o_done} !== 3'b100) begin
            n_err++;
            $display("FAIL read_wait2: got req/done %b/%b expected 1/00", o_bus_request, o_done);
        end
        i_bus_done      = 1'b1;
        i_bus_read_data = 32'h0001_0001;
        i_bus_status    = 2'b00;
        step();
        n_vec++;
        if ({o_bus_request, o_done, o_status} !== 5'b0_01_00 || o_read_data !== 32'h0001_0001) begin
            n_err++;
            $display("FAIL read_done: got req/done/st/data %b/%b/%b/%h expected 0/01/00/00010001", o_bus_request, o_done, o_status, o_read_data);
        end
        i_bus_done = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        step();
        n_vec++;
        if ({o_bus_request, o_done} !== 3'b000) begin
            n_err++;
            $display("FAIL read_after: got req/done %b/%b expected 0/00", o_bus_request, o_done);
        end
        step();
    endtask

    task automatic test_contention();
        logic [1:0]    exp_done;
        logic [AW-1:0] exp_addr;
        do_reset();
        drive_req(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 32'hFFFF_FFFF);
        drive_req(1'b1, 1'b1, 1'b0, 8'h20, 32'h0, 32'hFFFF_FFFF);
        i_bus_done      = 1'b1;
        i_bus_read_data = 32'h5555_AAAA;
        i_bus_status    = 2'b00;
        for (int k = 1; k <= 11; k++) begin
            step();
            exp_done = 2'b00;
            if (k % 3 == 2) exp_done = (((k / 3) % 2) == 0) ? 2'b01 : 2'b10;
            n_vec++;
            if (o_done !== exp_done || o_bus_request !== (k % 3 == 1)) begin
                n_err++;
                $display("FAIL rr_cycle%0d: got done/req %b/%b expected %b/%b", k, o_done, o_bus_request, exp_done, (k % 3 == 1));
            end
            if (k % 3 == 1) begin
                exp_addr = ((((k - 1) / 3) % 2) == 0) ? 8'h10 : 8'h20;
                n_vec++;
                if (o_bus_address !== exp_addr) begin
                    n_err++;
                    $display("FAIL rr_addr%0d: got %h expected %h", k, o_bus_address, exp_addr);
                end
            end
            if (k % 3 == 2) begin
                n_vec++;
                if (o_read_data !== 32'h5555_AAAA) begin
                    n_err++;
                    $display("FAIL rr_data%0d: got %h expected 5555aaaa", k, o_read_data);
                end
            end
        end
        i_request  = '0;
        i_bus_done = 1'b0;
        step();
        step();
    endtask

    task automatic test_write_capture();
        drive_req(1'b1, 1'b1, 1'b1, 8'h2C, 32'hA5A5_5A5A, 32'hFFFF_0000);
        i_bus_read_data = 32'hDEAD_BEEF;
        step();
        drive_req(1'b1, 1'b1, 1'b0, 8'hFF, 32'h1234_5678, 32'h0000_FFFF);
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if ({o_bus_request, o_bus_write, o_bus_address} !== {1'b1, 1'b1, 8'h2C} ||
                o_bus_write_data !== 32'hA5A5_5A5A || o_bus_strobe !== 32'hFFFF_0000) begin
                n_err++;
                $display("FAIL wr_capture%0d: got req/wr/addr/data/strb %b/%b/%h/%h/%h expected 1/1/2c/a5a55a5a/ffff0000",
                         c, o_bus_request, o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe);
            end
            if (c == 2) begin
                i_bus_done   = 1'b1;
                i_bus_status = 2'b00;
            end
            step();
        end
        n_vec++;
        if (o_done !== 2'b10 || o_read_data !== 32'h0 || o_status !== 2'b00) begin
            n_err++;
            $display("FAIL wr_done: got done/data/st %b/%h/%b expected 10/00000000/00", o_done, o_read_data, o_status);
        end
        i_bus_done = 1'b0;
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        step();
        step();
    endtask

    task automatic test_status_passthrough();
        drive_req(1'b1, 1'b1, 1'b0, 8'h34, 32'h0, 32'hFFFF_FFFF);
        step();
        i_bus_done      = 1'b1;
        i_bus_read_data = 32'hCAFE_F00D;
        i_bus_status    = 2'b11;
        step();
        n_vec++;
        if (o_done !== 2'b10 || o_status !== 2'b11 || o_read_data !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL st11_read: got done/st/data %b/%b/%h expected 10/11/cafef00d", o_done, o_status, o_read_data);
        end
        i_bus_done = 1'b0;
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        step();
        drive_req(1'b0, 1'b1, 1'b1, 8'h30, 32'h0BAD_0BAD, 32'hFFFF_FFFF);
        step();
        i_bus_done      = 1'b1;
        i_bus_read_data = 32'h1234_5678;
        i_bus_status    = 2'b10;
        step();
        n_vec++;
        if (o_done !== 2'b01 || o_status !== 2'b10 || o_read_data !== 32'h0) begin
            n_err++;
            $display("FAIL slverr_write: got done/st/data %b/%b/%h expected 01/10/00000000", o_done, o_status, o_read_data);
        end
        i_bus_done   = 1'b0;
        i_bus_status = 2'b00;
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        step();
        step();
    endtask

    task automatic test_reset_mid_op();
        drive_req(1'b0, 1'b1, 1'b0, 8'h40, 32'h0, 32'hFFFF_FFFF);
        step();
        step();
        n_vec++;
        if (o_bus_request !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_busy: got req %b expected 1", o_bus_request);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (o_bus_request !== 1'b0 || o_done !== 2'b00) begin
            n_err++;
            $display("FAIL midrst_async: got req/done %b/%b expected 0/00", o_bus_request, o_done);
        end
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        step();
        n_vec++;
        if (o_bus_request !== 1'b0 || o_done !== 2'b00) begin
            n_err++;
            $display("FAIL midrst_quiet: got req/done %b/%b expected 0/00", o_bus_request, o_done);
        end
        drive_req(1'b0, 1'b1, 1'b0, 8'h50, 32'h0, 32'hFFFF_FFFF);
        drive_req(1'b1, 1'b1, 1'b0, 8'h60, 32'h0, 32'hFFFF_FFFF);
        step();
        n_vec++;
        if (o_bus_request !== 1'b1 || o_bus_address !== 8'h50) begin
            n_err++;
            $display("FAIL midrst_prio: got req/addr %b/%h expected 1/50", o_bus_request, o_bus_address);
        end
        i_bus_done      = 1'b1;
        i_bus_read_data = 32'h0000_0050;
        step();
        n_vec++;
        if (o_done !== 2'b01) begin
            n_err++;
            $display("FAIL midrst_done: got %b expected 01", o_done);
        end
        i_bus_done = 1'b0;
        i_request  = '0;
        step();
        step();
    endtask

    task automatic test_timeout();
        int hi;
        int dn;
        hi = 0;
        dn = 0;
        drive_req(1'b0, 1'b1, 1'b0, 8'h70, 32'h0, 32'hFFFF_FFFF);
        i_bus_done      = 1'b0;
        i_bus_read_data = 32'h1111_2222;
        i_bus_status    = 2'b00;
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
        for (int c = 0; c < 20 && dn == 0; c++) begin
            step();
            if (o_bus_request) hi++;
            if (o_done != 2'b00) begin
                dn = 1;
                n_vec++;
                if (o_done !== 2'b01 || o_status !== 2'b10 || o_read_data !== 32'h0) begin
                    n_err++;
                    $display("FAIL tmo_done: got done/st/data %b/%b/%h expected 01/10/00000000", o_done, o_status, o_read_data);
                end
            end
        end
        n_vec++;
        if (dn != 1 || hi != 4) begin
            n_err++;
            $display("FAIL tmo_len: got done_seen/busy_cycles %0d/%0d expected 1/4", dn, hi);
        end
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        step();
        step();
`else
        for (int c = 0; c < 120; c++) begin
            step();
            if (o_bus_request) hi++;
            if (o_done != 2'b00) dn++;
        end
        n_vec++;
        if (hi != 120 || dn != 0) begin
            n_err++;
            $display("FAIL no_tmo: got busy_cycles/dones %0d/%0d expected 120/0", hi, dn);
        end
        i_bus_done = 1'b1;
        step();
        n_vec++;
        if (o_done !== 2'b01 || o_read_data !== 32'h1111_2222) begin
            n_err++;
            $display("FAIL no_tmo_done: got done/data %b/%h expected 01/11112222", o_done, o_read_data);
        end
        i_bus_done = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        step();
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write_capture();
        test_status_passthrough();
        test_reset_mid_op();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rggen_bus_arbiter.md
Name: rggen_bus_arbiter

Overview:
- Shares one register-block local bus between REQUESTERS independent bus masters, e.g. two host interfaces driving the same register map.
- Sits between the host-side masters and the bus splitter input.
- Round-robin grant, one transaction in flight at a time.
- Captures the command at grant and returns read data/status to the granted requester only.

Parameters:
- REQUESTERS, 2, number of upstream masters (1..16)
- ADDRESS_WIDTH, 8, local byte address width
- DATA_WIDTH, 32, bus data width
- TIMEOUT_CYCLES, 255, downstream wait limit; used only with the optional feature

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- i_request  input  REQUESTERS  per-requester transaction request
- i_write  input  REQUESTERS  1 = write, 0 = read
- i_address  input  REQUESTERS*ADDRESS_WIDTH  packed addresses, requester k at slice k
- i_write_data  input  REQUESTERS*DATA_WIDTH  packed write data
- i_strobe  input  REQUESTERS*DATA_WIDTH  packed bit-enable masks
- o_done  output  REQUESTERS  one-cycle completion pulse to the granted requester
- o_read_data  output  DATA_WIDTH  read data, valid while any o_done is high
- o_status  output  2  00 OKAY, 10 SLVERR; valid with o_done
- o_bus_request  output  1  downstream request
- o_bus_write  output  1  downstream direction
- o_bus_address  output  ADDRESS_WIDTH  downstream address
- o_bus_write_data  output  DATA_WIDTH  downstream write data
- o_bus_strobe  output  DATA_WIDTH  downstream mask
- i_bus_done  input  1  downstream completion
- i_bus_read_data  input  DATA_WIDTH  downstream read data
- i_bus_status  input  2  downstream status

Behaviour:
- Reset values: state IDLE; all outputs 0; rotating pointer last = REQUESTERS-1, so requester 0 has top priority after reset.
- Reset is fully asynchronous and may occur mid-transaction. The transaction is dropped, no o_done is issued, and the downstream request deasserts immediately.

FSM:
- IDLE:
  - If any i_request[k] is high, grant the first requester at or after (last+1) mod REQUESTERS, wrapping.
  - Register grant index, i_write, address, write_data and strobe of that requester.
  - Set last = grant and go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - o_bus_request = 1; o_bus_* driven from the captured registers, stable for the whole state.
  - On i_bus_done, register i_bus_read_data and i_bus_status, deassert o_bus_request at the next edge, go to DONE.
- DONE:
  - o_done[grant] = 1 for exactly one cycle, all other o_done bits 0.
  - o_read_data/o_status hold the captured values; go to IDLE.
  - o_read_data is 0 for writes.

Latency and rules:
- Minimum latency: request sampled at cycle N, o_bus_request high at N+1, and with i_bus_done at N+1, o_done at N+2. Back-to-back throughput is one transaction per 3 cycles.
- A requester holds i_request and its payload until it sees o_done, then deasserts i_request in the following cycle. Payload changes after grant are ignored because the command is captured.
- A requester dropping i_request mid-transaction does not abort it; the transaction completes and o_done is still pulsed.
- i_bus_done outside BUSY is ignored.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,REQUESTERS-1,0. No requester waits more than REQUESTERS-1 transactions.
- REQUESTERS = 1: the arbiter degenerates to a registered pass-through with the same latency.
- i_bus_status is passed through unmodified; 01/11 are forwarded as received.

Optional Feature:
- Macro: RGGEN_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter, cleared on BUSY entry, increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without i_bus_done, deassert o_bus_request and go to DONE with o_status = 10 and o_read_data = 0.
  - If i_bus_done and the timeout coincide, i_bus_done wins and normal data/status are returned.
- Undefined: no counter; BUSY waits indefinitely for i_bus_done.

Test Plan:
- Single read: req0 read addr 0x08, downstream returns 0x00010001 after 2 wait cycles -> o_bus_request high 3 cycles, o_done[0] one pulse with o_read_data = 0x00010001 and o_status = 00; o_done[1] stays 0.
- Simultaneous contention: req0 and req1 assert in the same cycle and re-request immediately, 4 transactions -> grant order 0,1,0,1 with no gaps beyond the 3-cycle cadence.
- Write capture: req1 write addr 0x2C, data 0xA5A5_5A5A, strobe 0xFFFF_0000; payload changes one cycle after grant -> downstream sees the original values throughout BUSY.
- Error passthrough: i_bus_status = 10 on a write -> o_status = 10 with o_done pulsed.
- Reset mid-op: assert rst while in BUSY -> o_bus_request is 0 immediately, no o_done, and the next request from req0 and req1 grants req0 first.
- Timeout (macro defined, TIMEOUT_CYCLES = 4): no i_bus_done -> o_bus_request drops after 4 BUSY cycles, o_done with o_status = 10 and o_read_data = 0. Macro undefined: the request stays high for 100+ cycles.
